// File: rtl/conv_pkg.sv
// Shared word type and signed-max helper for the convolution output path.
package conv_pkg;
   localparam int T = 16;

   typedef logic signed [T-1:0] word_t;

   function automatic word_t smax(input word_t a, input word_t b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/conv_pool_rx.sv
// Non-overlapping signed max-pool of W-word windows over L-word vectors; result registered on the Wth accepted word.
// Single output register: x_ready drops only when a window would complete while an undelivered result is stalled.
module conv_pool_rx #(
   parameter int T = conv_pkg::T,
   parameter int L = 27,
   parameter int W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [T-1:0] x_data,
   input  logic                x_valid,
   output logic                x_ready,
   output logic signed [T-1:0] y_data,
   output logic                y_valid,
   input  logic                y_ready,
   output logic                y_last
);
   import conv_pkg::*;

   localparam int WCW = (W > 1) ? $clog2(W) : 1;
   localparam int PCW = (L > 1) ? $clog2(L) : 1;
   localparam logic [WCW-1:0] WIN_LAST = WCW'(W - 1);
   localparam logic [PCW-1:0] POS_LAST = PCW'(L - 1);

   if ((L % W) != 0) begin : g_bad_len
      $error("conv_pool_rx: L must be a multiple of W");
   end
   if (T != $bits(word_t)) begin : g_bad_width
      $error("conv_pool_rx: T must match the conv_pkg word width");
   end

   logic [WCW-1:0] win_cnt;
   logic [PCW-1:0] pos_cnt;
   word_t          run_max;
   word_t          cand;
   logic           x_fire;
   logic           y_fire;
   logic           win_done;

   assign win_done = (win_cnt == WIN_LAST);
   assign x_ready  = !win_done || !y_valid || y_ready;
   assign x_fire   = x_valid && x_ready;
   assign y_fire   = y_valid && y_ready;

   // First word of a window seeds the running max.
   always_comb begin
      cand = x_data;
      if (win_cnt != '0) begin
         cand = smax(run_max, x_data);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt <= '0;
         pos_cnt <= '0;
         run_max <= '0;
         y_data  <= '0;
         y_valid <= 1'b0;
         y_last  <= 1'b0;
      end else begin
         if (y_fire) begin
            y_valid <= 1'b0;
         end
         if (x_fire) begin
            run_max <= cand;
            // A completing window overrides the drain so y_valid stays high.
            if (win_done) begin
               y_data  <= cand;
               y_valid <= 1'b1;
               y_last  <= (pos_cnt == POS_LAST);
               win_cnt <= '0;
            end else begin
               win_cnt <= win_cnt + 1'b1;
            end
            if (pos_cnt == POS_LAST) begin
               pos_cnt <= '0;
            end else begin
               pos_cnt <= pos_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_conv_pool_rx.sv
// Scoreboard bench for conv_pool_rx: directed vectors queue expected results, a negedge monitor checks them.
module tb_conv_pool_rx;
   localparam int T = 16;
   localparam int L = 27;
   localparam int W = 3;
   localparam int NOUT = L / W;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic signed [T-1:0] x_data = '0;
   logic                x_valid = 1'b0;
   logic                x_ready;
   logic signed [T-1:0] y_data;
   logic                y_valid;
   logic                y_ready = 1'b1;
   logic                y_last;

   typedef struct packed {
      logic signed [T-1:0] d;
      logic                l;
   } exp_t;

   exp_t                q[$];
   logic signed [T-1:0] vec[L];
   int                  checks = 0;
   int                  failures = 0;
   int                  ready_mode = 0;   // 0: y_ready=1, 1: y_ready=0, 2: random

   conv_pool_rx #(.T(T), .L(L), .W(W)) dut (
      .clk(clk), .reset(reset),
      .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
      .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_last(y_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       y_ready = 1'b1;
         1:       y_ready = 1'b0;
         default: y_ready = 1'($urandom_range(1, 0));
      endcase
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic push(input int d, input bit l);
      exp_t e;
      e.d = T'(d);
      e.l = l;
      q.push_back(e);
   endtask

   // Bench reference for the random phase: plain windowed signed max.
   task automatic push_model();
      logic signed [T-1:0] m;
      for (int k = 0; k < NOUT; k++) begin
         m = vec[k*W];
         for (int j = 1; j < W; j++) begin
            if (vec[k*W+j] > m) m = vec[k*W+j];
         end
         push(int'(m), k == NOUT - 1);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the word is accepted.
   task automatic send_word(input logic signed [T-1:0] d, input bit gaps);
      int n;
      bit f;
      n = 0;
      if (gaps) begin
         while ($urandom_range(1, 0) == 1) begin
            x_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      x_valid = 1'b1;
      x_data  = d;
      do begin
         @(negedge clk);
         f = x_ready;
         @(posedge clk); #1;
         n++;
         if (n > 2000) begin
            $display("FAIL accept_timeout actual=stalled required=accept");
            $fatal(1);
         end
      end while (!f);
      x_valid = 1'b0;
   endtask

   task automatic send_vec(input bit gaps);
      for (int i = 0; i < L; i++) send_word(vec[i], gaps);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor: cycle model of y_valid/x_ready plus scoreboard pop on each output transfer.
   int                  acc_cnt = 0;
   bit                  armed = 0;
   bit                  exp_v = 0;
   bit                  stalled = 0;
   logic signed [T-1:0] prev_d;
   logic                prev_l;

   always @(negedge clk) begin
      bit   xf;
      bit   yf;
      bit   old_v;
      exp_t e;
      xf = x_valid && x_ready;
      yf = y_valid && y_ready;
      if (armed) begin
         chk("y_valid_seq", int'(y_valid), int'(exp_v));
         chk("x_ready", int'(x_ready), int'(!(acc_cnt == W - 1 && exp_v && !y_ready)));
         if (stalled) begin
            chk("stall_data", int'(y_data), int'(prev_d));
            chk("stall_last", int'(y_last), int'(prev_l));
         end
      end
      if (yf && !reset) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0d required=none", y_data);
         end else begin
            e = q.pop_front();
            chk("y_data", int'(y_data), int'($signed(e.d)));
            chk("y_last", int'(y_last), int'(e.l));
         end
      end
      old_v   = exp_v;
      stalled = 1'b0;
      if (reset) begin
         acc_cnt = 0;
         exp_v   = 1'b0;
         armed   = 1'b1;
      end else begin
         if (xf && acc_cnt == W - 1) exp_v = 1'b1;
         else if (old_v && y_ready)  exp_v = 1'b0;
         stalled = old_v && !y_ready;
         prev_d  = y_data;
         prev_l  = y_last;
         if (xf) acc_cnt = (acc_cnt + 1) % W;
      end
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_y_valid", int'(y_valid), 0);
      chk("rst_y_data", int'(y_data), 0);
      chk("rst_y_last", int'(y_last), 0);
      chk("rst_x_ready", int'(x_ready), 1);
      @(posedge clk); #1;

      // Ramp 0..26
      for (int i = 0; i < L; i++) vec[i] = T'(i);
      for (int k = 0; k < NOUT; k++) push(3*k + 2, k == NOUT - 1);
      send_vec(0);
      wait_drain();

      // Extremes first, then ramp from -4
      vec[0] = -16'sd32768; vec[1] = -16'sd1;     vec[2] = -16'sd5;
      vec[3] = -16'sd32768; vec[4] = -16'sd32768; vec[5] = -16'sd32768;
      vec[6] = 16'sd32767;  vec[7] = -16'sd32768; vec[8] = 16'sd0;
      for (int i = 9; i < L; i++) vec[i] = T'(i - 13);
      push(-1, 0); push(-32768, 0); push(32767, 0);
      for (int k = 3; k < NOUT; k++) push(3*k - 11, k == NOUT - 1);
      send_vec(0);
      wait_drain();

      // Descending data with a 20-cycle output stall mid-stream
      for (int i = 0; i < L; i++) vec[i] = T'(300 - 11*i);
      for (int k = 0; k < NOUT; k++) push(300 - 33*k, k == NOUT - 1);
      fork
         send_vec(0);
         begin
            repeat (4) @(posedge clk);
            #1 ready_mode = 1;
            repeat (20) @(posedge clk);
            #1 ready_mode = 0;
         end
      join
      wait_drain();

      // Reset with a pending output after 13 words
      push(202, 0); push(205, 0); push(208, 0);
      for (int i = 0; i < 11; i++) send_word(T'(200 + i), 0);
      ready_mode = 1;
      send_word(T'(211), 0);
      send_word(T'(212), 0);
      @(negedge clk);
      chk("pend_valid", int'(y_valid), 1);
      chk("pend_data", int'(y_data), 211);
      chk("pend_last", int'(y_last), 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_y_valid", int'(y_valid), 0);
      chk("midrst_queue", q.size(), 0);
      ready_mode = 0;
      @(posedge clk); #1;
      for (int i = 0; i < L; i++) vec[i] = T'(100 + i);
      for (int k = 0; k < NOUT; k++) push(3*k + 102, k == NOUT - 1);
      send_vec(0);
      wait_drain();

      // Random data with random x_valid gaps and y_ready
      ready_mode = 2;
      for (int v = 0; v < 312; v++) begin
         for (int i = 0; i < L; i++) vec[i] = T'($urandom);
         push_model();
         send_vec(1);
      end
      ready_mode = 0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_pool_rx.md
Name: conv_pool_rx

Overview:
- Stream receiver for the convolution output interface; sits directly downstream of conv_32_6_16_1.
- Accepts signed T-bit results over a valid/ready handshake. Each vector is L values (27 for the N=32, M=6 configuration).
- Applies non-overlapping signed max-pooling with window W.
- Emits L/W pooled values per vector on its own valid/ready port, flagging the last value of each vector.

Parameters:
- T, 16, data word width (signed two's complement).
- L, 27, input values per vector (N-M+1 of the upstream convolution).
- W, 3, pooling window size; L must be a multiple of W, checked by an elaboration-time assertion.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  reset; synchronous, active-high.
- x_data  input  T  signed input word from the convolution output.
- x_valid  input  1  x_data valid.
- x_ready  output  1  block can accept x_data this cycle.
- y_data  output  T  signed pooled maximum.
- y_valid  output  1  y_data valid.
- y_ready  input  1  downstream accepts y_data this cycle.
- y_last  output  1  y_data is the final pooled value (index L/W-1) of a vector.

Behaviour:
- Reset (posedge clk with reset=1):
  - win_cnt=0, pos_cnt=0, run_max=0.
  - y_valid=0, y_data=0, y_last=0.
  - Reset wins over any simultaneous handshake.
- Reset mid-operation discards any partial window and any undelivered y_data; the next accepted word starts a new vector.
- Input transfer occurs on posedge when x_valid && x_ready.
- x_ready = (win_cnt != W-1) || !y_valid || y_ready.
  - Combinational path from y_ready to x_ready is permitted.
  - x_ready=1 in the cycle after reset.
- On input transfer:
  - win_cnt==0: run_max <= x_data.
  - Otherwise: run_max <= max(run_max, x_data), signed comparison.
  - win_cnt==W-1: the result max(run_max, x_data) is loaded into the output register: y_data <= result, y_valid <= 1, y_last <= (pos_cnt==L-1). win_cnt wraps to 0.
  - Otherwise win_cnt increments.
  - pos_cnt increments and wraps from L-1 to 0.
- Output transfer occurs on posedge when y_valid && y_ready.
  - y_valid <= 0, unless a new window completes in the same cycle; then the new value loads and y_valid stays 1.
- y_data and y_last hold stable while y_valid && !y_ready.
- Latency: y_valid rises on the posedge that accepts the W-th word of a window, i.e. 1 cycle after that word is presented.
- Throughput: 1 input word per cycle sustained while y_ready=1.
- No combinational path from x_data/x_valid to any output.
- Arithmetic:
  - Compare only; no width growth; y_data is exactly T bits.
  - Full range allowed, including -2^(T-1).
  - Ties: either equal value is acceptable, since outputs are identical.
- x_data is ignored when x_valid=0 and may be X.
- y_data is don't-care when y_valid=0, but must not be X after reset.

Decomposition:
- Shared package conv_pkg:
  - localparam T default.
  - typedef word_t = logic signed [T-1:0].
  - Function smax(word_t a, word_t b) returning the signed maximum.
- No sub-module. Window/position counters, running max and the single output register fit in one module of roughly 150 lines.

Test Plan:
- Reset, then vector 0,1,...,26 with x_valid=1 and y_ready=1 held:
  - y = 2,5,8,...,26, one per 3 input cycles.
  - y_last=1 only on 26.
  - First y_valid 1 cycle after the 3rd word is accepted.
- Negative and extreme values, windows {-32768,-1,-5}, {-32768,-32768,-32768}, {32767,-32768,0} -> y = -1, -32768, 32767.
- Backpressure: y_ready=0 for 20 cycles during a stream:
  - x_ready drops only while win_cnt==2 and y_valid=1.
  - y_data stays stable while stalled.
  - No values are lost or duplicated.
  - When y_ready is re-asserted, a completing window and the drain occur in the same cycle with y_valid held at 1.
- Reset mid-operation: after 13 words of a vector with an output pending, pulse reset for 1 cycle:
  - y_valid=0 the next cycle.
  - A following fresh vector 100..126 yields 102,105,...,126 with y_last on 126.
- Random x_valid/y_ready at 50% each, 312 vectors of random signed data:
  - 2808 outputs match the golden model file, 0 errors.
  - y_last asserted on every 9th output.
